// File: rtl/mist1032sa_uart_rx_fifo_pkg.sv
// Shared constants and types for the UART receive FIFO slice.
// Default depth and timeout are shared with the receiver and transmitter.
package mist1032sa_uart_rx_fifo_pkg;

  localparam int          UART_DEFAULT_DEPTH_N        = 4;
  localparam int          UART_TIMEOUT_W              = 20;
  localparam logic [19:0] UART_DEFAULT_TIMEOUT_CYCLES = 20'd17360;
  localparam int          UART_RD_DATA_W              = 8;

  typedef logic [UART_RD_DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/mist1032sa_uart_rx_fifo_if.sv
// Byte stream from the UART receiver and pop handshake from the bus side.
// master: receiver/bus side, slave: the FIFO.
interface mist1032sa_uart_rx_fifo_if;
  import mist1032sa_uart_rx_fifo_pkg::*;

  logic       iRX_VALID;
  uart_byte_t iRX_DATA;
  logic       iRD_REQ;
  logic       oRD_VALID;
  uart_byte_t oRD_DATA;

  modport master (
    output iRX_VALID, iRX_DATA, iRD_REQ,
    input  oRD_VALID, oRD_DATA
  );

  modport slave (
    input  iRX_VALID, iRX_DATA, iRD_REQ,
    output oRD_VALID, oRD_DATA
  );

endinterface

// File: rtl/mist1032sa_uart_rx_fifo_ram.sv
// 2**P_ADDR_W x 8 storage: synchronous write, registered read port.
// The read register holds its value when no read is issued, which is what
// gives oRD_DATA its hold-previous-value behaviour.
module mist1032sa_uart_rx_fifo_ram
  import mist1032sa_uart_rx_fifo_pkg::*;
#(
  parameter int P_ADDR_W = 4
) (
  input  logic                iCLOCK,
  input  logic                inRESET,
  input  logic                wr_en,
  input  logic [P_ADDR_W-1:0] wr_addr,
  input  uart_byte_t          wr_data,
  input  logic                rd_en,
  input  logic [P_ADDR_W-1:0] rd_addr,
  output uart_byte_t          rd_data
);

  uart_byte_t mem [0:(1<<P_ADDR_W)-1];

  // Array write; no reset so it can map onto RAM primitives.
  always_ff @(posedge iCLOCK) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; old contents are returned on a same-address write.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)   rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/mist1032sa_uart_rx_fifo.sv
// UART receive FIFO: pointers, fill count, overrun/IRQ flags and receive timeout.
// Optional feature macro: MIST1032SA_UART_RXFIFO_TIMEOUT_EN builds the idle
// timeout counter; without it oTIMEOUT is tied low.
module mist1032sa_uart_rx_fifo
  import mist1032sa_uart_rx_fifo_pkg::*;
#(
  parameter int                        P_DEPTH_N        = UART_DEFAULT_DEPTH_N,
  parameter logic [UART_TIMEOUT_W-1:0] P_TIMEOUT_CYCLES = UART_DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   iCLOCK,
  input  logic                   inRESET,
  mist1032sa_uart_rx_fifo_if.slave rx_bus,
  output logic                   oEMPTY,
  output logic                   oFULL,
  output logic [P_DEPTH_N:0]     oCOUNT,
  input  logic                   iFLUSH,
  input  logic                   iOVERRUN_CLR,
  output logic                   oOVERRUN,
  input  logic [P_DEPTH_N:0]     iIRQ_THRESHOLD,
  output logic                   oTIMEOUT,
  output logic                   oIRQ
);

  localparam logic [P_DEPTH_N:0]   CNT_FULL = (P_DEPTH_N+1)'(1 << P_DEPTH_N);
  localparam logic [P_DEPTH_N:0]   CNT_ONE  = (P_DEPTH_N+1)'(1);
  localparam logic [P_DEPTH_N-1:0] PTR_ONE  = P_DEPTH_N'(1);

  logic [P_DEPTH_N-1:0] wr_ptr, rd_ptr;
  logic [P_DEPTH_N:0]   count_q, count_nxt, thr_eff;
  logic                 empty_q, full_q, rd_valid_q, overrun_q, timeout_q;
  logic                 push, pop, drop;
  uart_byte_t           rd_data_w;

  // Push/pop decisions on pre-edge state; flush suppresses both.
  always_comb begin
    pop       = rx_bus.iRD_REQ & ~empty_q & ~iFLUSH;
    push      = rx_bus.iRX_VALID & (~full_q | (rx_bus.iRD_REQ & ~empty_q)) & ~iFLUSH;
    drop      = rx_bus.iRX_VALID & ~push & ~iFLUSH;
    count_nxt = count_q;
    if (push & ~pop)      count_nxt = count_q + CNT_ONE;
    else if (pop & ~push) count_nxt = count_q - CNT_ONE;
  end

  // Pointers, count and the registered level flags.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else if (iFLUSH) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      count_q    <= count_nxt;
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == CNT_FULL);
      rd_valid_q <= pop;
    end
  end

  // Sticky overrun; a dropped byte beats a clear in the same cycle.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)          overrun_q <= 1'b0;
    else if (drop)         overrun_q <= 1'b1;
    else if (iOVERRUN_CLR) overrun_q <= 1'b0;
  end

`ifdef MIST1032SA_UART_RXFIFO_TIMEOUT_EN
  localparam logic [UART_TIMEOUT_W-1:0] TMO_LAST = P_TIMEOUT_CYCLES - 20'd1;

  logic [UART_TIMEOUT_W-1:0] tmo_cnt;

  // Idle counter while data sits unread; saturates once the flag is raised.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (iFLUSH) begin
      tmo_cnt   <= '0;
      timeout_q <= 1'b0;
    end else if (push | pop) begin
      tmo_cnt <= '0;
      if (pop) timeout_q <= 1'b0;
    end else if (empty_q) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt == TMO_LAST) begin
      timeout_q <= 1'b1;
    end else begin
      tmo_cnt <= tmo_cnt + 20'd1;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^P_TIMEOUT_CYCLES;
  assign timeout_q          = 1'b0;
`endif

  mist1032sa_uart_rx_fifo_ram #(
    .P_ADDR_W (P_DEPTH_N)
  ) u_ram (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (rx_bus.iRX_DATA),
    .rd_en   (pop),
    .rd_addr (rd_ptr),
    .rd_data (rd_data_w)
  );

  // A threshold of zero behaves as one so the IRQ never fires on an empty FIFO.
  assign thr_eff = (iIRQ_THRESHOLD == '0) ? CNT_ONE : iIRQ_THRESHOLD;

  assign rx_bus.oRD_VALID = rd_valid_q;
  assign rx_bus.oRD_DATA  = rd_data_w;
  assign oEMPTY           = empty_q;
  assign oFULL            = full_q;
  assign oCOUNT           = count_q;
  assign oOVERRUN         = overrun_q;
  assign oTIMEOUT         = timeout_q;
  assign oIRQ             = (count_q >= thr_eff) | timeout_q;

endmodule

// File: tb/tb_mist1032sa_uart_rx_fifo.sv
// Self-checking bench for mist1032sa_uart_rx_fifo (depth 16, timeout 8 cycles).
module tb_mist1032sa_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int TMO   = 8;

  logic       iCLOCK = 1'b0;
  logic       inRESET = 1'b0;
  logic       iFLUSH = 1'b0;
  logic       iOVERRUN_CLR = 1'b0;
  logic [4:0] iIRQ_THRESHOLD = '0;
  logic       oEMPTY, oFULL, oOVERRUN, oTIMEOUT, oIRQ;
  logic [4:0] oCOUNT;

  mist1032sa_uart_rx_fifo_if bus();

  mist1032sa_uart_rx_fifo #(
    .P_DEPTH_N        (4),
    .P_TIMEOUT_CYCLES (20'd8)
  ) dut (
    .iCLOCK         (iCLOCK),
    .inRESET        (inRESET),
    .rx_bus         (bus),
    .oEMPTY         (oEMPTY),
    .oFULL          (oFULL),
    .oCOUNT         (oCOUNT),
    .iFLUSH         (iFLUSH),
    .iOVERRUN_CLR   (iOVERRUN_CLR),
    .oOVERRUN       (oOVERRUN),
    .iIRQ_THRESHOLD (iIRQ_THRESHOLD),
    .oTIMEOUT       (oTIMEOUT),
    .oIRQ           (oIRQ)
  );

  always #5 iCLOCK = ~iCLOCK;

`ifdef MIST1032SA_UART_RXFIFO_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model: a queue of bytes plus the flags, stepped once per clock.
  logic [7:0] mq[$];
  bit         m_rdv;
  logic [7:0] m_rdd;
  bit         m_ovr;
  bit         m_tmo;
  int         idle_run;

  typedef struct {
    bit         rxv;
    logic [7:0] d;
    bit         rr;
    bit         fl;
    logic [4:0] thr;
    bit         e_rdv;
    logic [7:0] e_rdd;
    int         e_cnt;
    bit         e_empty;
    bit         e_irq;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rdv = 0; m_rdd = 8'h00; m_ovr = 0; m_tmo = 0; idle_run = 0;
  endtask

  task automatic model_update();
    int  sz;
    bit  popd, pushd;
    sz    = mq.size();
    popd  = bus.iRD_REQ && sz > 0;
    pushd = bus.iRX_VALID && (sz < DEPTH || popd);
    if (iFLUSH) begin
      mq.delete();
      m_rdv = 0; m_tmo = 0; idle_run = 0;
      if (iOVERRUN_CLR) m_ovr = 0;
    end else begin
      if (bus.iRX_VALID && !pushd) m_ovr = 1;
      else if (iOVERRUN_CLR)       m_ovr = 0;
      if (popd) m_rdd = mq.pop_front();
      m_rdv = popd;
      if (pushd) mq.push_back(bus.iRX_DATA);
      if (TMO_EN) begin
        if (pushd || popd) begin
          idle_run = 0;
          if (popd) m_tmo = 0;
        end else if (sz == 0) begin
          idle_run = 0;
        end else begin
          idle_run++;
          if (idle_run >= TMO) m_tmo = 1;
        end
      end
    end
  endtask

  task automatic model_compare();
    int thr_eff;
    bit e_irq;
    thr_eff = (iIRQ_THRESHOLD == 0) ? 1 : int'(iIRQ_THRESHOLD);
    e_irq   = (mq.size() >= thr_eff) || m_tmo;
    checks++;
    if (bus.oRD_VALID !== m_rdv || bus.oRD_DATA !== m_rdd || oCOUNT !== 5'(mq.size()) ||
        oEMPTY !== (mq.size() == 0) || oFULL !== (mq.size() == DEPTH) ||
        oOVERRUN !== m_ovr || oTIMEOUT !== m_tmo || oIRQ !== e_irq) begin
      errors++;
      $display("FAIL model cyc=%0d got rdv=%b rdd=%h cnt=%0d emp=%b full=%b ovr=%b tmo=%b irq=%b expected rdv=%b rdd=%h cnt=%0d ovr=%b tmo=%b irq=%b",
               cyc, bus.oRD_VALID, bus.oRD_DATA, oCOUNT, oEMPTY, oFULL, oOVERRUN, oTIMEOUT, oIRQ,
               m_rdv, m_rdd, mq.size(), m_ovr, m_tmo, e_irq);
    end
  endtask

  task automatic drive(bit rxv, logic [7:0] d, bit rr, bit fl, bit clr);
    bus.iRX_VALID = rxv;
    bus.iRX_DATA  = d;
    bus.iRD_REQ   = rr;
    iFLUSH        = fl;
    iOVERRUN_CLR  = clr;
  endtask

  task automatic step();
    model_update();
    @(posedge iCLOCK);
    #1;
    cyc++;
    model_compare();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed table: basic order, empty read, no bypass, flush, IRQ threshold.
    vecs[0]  = '{1, 8'hA5, 0, 0, 5'd0, 0, 8'h00, 1, 0, 1};
    vecs[1]  = '{1, 8'h3C, 0, 0, 5'd0, 0, 8'h00, 2, 0, 1};
    vecs[2]  = '{0, 8'h00, 1, 0, 5'd0, 1, 8'hA5, 1, 0, 1};
    vecs[3]  = '{0, 8'h00, 1, 0, 5'd0, 1, 8'h3C, 0, 1, 0};
    vecs[4]  = '{0, 8'h00, 1, 0, 5'd0, 0, 8'h3C, 0, 1, 0};
    vecs[5]  = '{1, 8'h11, 1, 0, 5'd0, 0, 8'h3C, 1, 0, 1};
    vecs[6]  = '{0, 8'h00, 1, 0, 5'd0, 1, 8'h11, 0, 1, 0};
    vecs[7]  = '{1, 8'h01, 0, 0, 5'd0, 0, 8'h11, 1, 0, 1};
    vecs[8]  = '{1, 8'h02, 0, 0, 5'd0, 0, 8'h11, 2, 0, 1};
    vecs[9]  = '{1, 8'h99, 1, 1, 5'd0, 0, 8'h11, 0, 1, 0};
    vecs[10] = '{0, 8'h00, 0, 0, 5'd0, 0, 8'h11, 0, 1, 0};
    vecs[11] = '{1, 8'h21, 0, 0, 5'd4, 0, 8'h11, 1, 0, 0};
    vecs[12] = '{1, 8'h22, 0, 0, 5'd4, 0, 8'h11, 2, 0, 0};
    vecs[13] = '{1, 8'h23, 0, 0, 5'd4, 0, 8'h11, 3, 0, 0};
    vecs[14] = '{1, 8'h24, 0, 0, 5'd4, 0, 8'h11, 4, 0, 1};
    vecs[15] = '{0, 8'h00, 1, 0, 5'd4, 1, 8'h21, 3, 0, 0};
    vecs[16] = '{0, 8'h00, 1, 0, 5'd4, 1, 8'h22, 2, 0, 0};
    vecs[17] = '{0, 8'h00, 1, 0, 5'd4, 1, 8'h23, 1, 0, 0};
    vecs[18] = '{0, 8'h00, 1, 0, 5'd4, 1, 8'h24, 0, 1, 0};

    drive(0, 8'h00, 0, 0, 0);
    model_reset();
    repeat (3) @(posedge iCLOCK);
    #1;
    chk("rst_rdv",   32'(bus.oRD_VALID), 32'd0);
    chk("rst_rdd",   32'(bus.oRD_DATA),  32'h00);
    chk("rst_empty", 32'(oEMPTY),        32'd1);
    chk("rst_full",  32'(oFULL),         32'd0);
    chk("rst_count", 32'(oCOUNT),        32'd0);
    chk("rst_ovr",   32'(oOVERRUN),      32'd0);
    chk("rst_tmo",   32'(oTIMEOUT),      32'd0);
    chk("rst_irq",   32'(oIRQ),          32'd0);
    inRESET = 1'b1;

    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].rxv, vecs[i].d, vecs[i].rr, vecs[i].fl, 0);
      iIRQ_THRESHOLD = vecs[i].thr;
      step();
      chk($sformatf("vec%0d_rdv", i),   32'(bus.oRD_VALID), 32'(vecs[i].e_rdv));
      chk($sformatf("vec%0d_rdd", i),   32'(bus.oRD_DATA),  32'(vecs[i].e_rdd));
      chk($sformatf("vec%0d_cnt", i),   32'(oCOUNT),        32'(vecs[i].e_cnt));
      chk($sformatf("vec%0d_empty", i), 32'(oEMPTY),        32'(vecs[i].e_empty));
      chk($sformatf("vec%0d_irq", i),   32'(oIRQ),          32'(vecs[i].e_irq));
    end

    // Overflow: 17 pushes into 16 entries, then clear overrun.
    iIRQ_THRESHOLD = 5'd0;
    for (int i = 0; i < 17; i++) begin
      drive(1, 8'(i), 0, 0, 0);
      step();
    end
    chk("ovf_full",  32'(oFULL),    32'd1);
    chk("ovf_count", 32'(oCOUNT),   32'd16);
    chk("ovf_ovr",   32'(oOVERRUN), 32'd1);
    drive(0, 8'h00, 0, 0, 1);
    step();
    chk("ovr_clr", 32'(oOVERRUN), 32'd0);

    // Push and pop together while full: no overrun, level unchanged.
    drive(1, 8'h77, 1, 0, 0);
    step();
    chk("fullpp_ovr",   32'(oOVERRUN), 32'd0);
    chk("fullpp_count", 32'(oCOUNT),   32'd16);
    chk("fullpp_rdd",   32'(bus.oRD_DATA), 32'h00);
    for (int i = 1; i <= 16; i++) begin
      drive(0, 8'h00, 1, 0, 0);
      step();
      chk($sformatf("drain%0d", i), 32'(bus.oRD_DATA), (i == 16) ? 32'h77 : 32'(i));
    end
    chk("drain_empty", 32'(oEMPTY), 32'd1);

    // Overrun set beats clear; flush keeps the overrun flag.
    for (int i = 0; i < 16; i++) begin
      drive(1, 8'(8'h40 + i), 0, 0, 0);
      step();
    end
    drive(1, 8'hEE, 0, 0, 1);
    step();
    chk("setwins_ovr", 32'(oOVERRUN), 32'd1);
    drive(0, 8'h00, 0, 1, 0);
    step();
    chk("flush_ovr",   32'(oOVERRUN), 32'd1);
    chk("flush_count", 32'(oCOUNT),   32'd0);
    drive(0, 8'h00, 0, 0, 1);
    step();
    chk("ovr_clr2", 32'(oOVERRUN), 32'd0);

    // Receive timeout: one byte, then idle.
    iIRQ_THRESHOLD = 5'd16;
    drive(1, 8'h5A, 0, 0, 0);
    step();
    for (int k = 1; k <= TMO + 2; k++) begin
      drive(0, 8'h00, 0, 0, 0);
      step();
      chk($sformatf("tmo_k%0d", k), 32'(oTIMEOUT), 32'(TMO_EN && k >= TMO));
      chk($sformatf("tmo_irq_k%0d", k), 32'(oIRQ), 32'(TMO_EN && k >= TMO));
    end
    drive(0, 8'h00, 1, 0, 0);
    step();
    chk("tmo_pop_clr", 32'(oTIMEOUT), 32'd0);
    chk("tmo_pop_irq", 32'(oIRQ),     32'd0);
    chk("tmo_pop_rdd", 32'(bus.oRD_DATA), 32'h5A);

    // Reset mid-operation discards contents immediately.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'(8'hC0 + i), 0, 0, 0);
      step();
    end
    drive(0, 8'h00, 0, 0, 0);
    #2;
    inRESET = 1'b0;
    #1;
    model_reset();
    chk("midrst_count", 32'(oCOUNT), 32'd0);
    chk("midrst_empty", 32'(oEMPTY), 32'd1);
    chk("midrst_rdd",   32'(bus.oRD_DATA), 32'h00);
    @(posedge iCLOCK);
    #1;
    inRESET = 1'b1;

    // Randomized traffic against the queue model, in blocks of varying load.
    for (int blk = 0; blk < 4; blk++) begin
      int p_rx, p_rd;
      case (blk)
        0:       begin p_rx = 70; p_rd = 30; end
        1:       begin p_rx = 30; p_rd = 70; end
        2:       begin p_rx = 50; p_rd = 50; end
        default: begin p_rx = 8;  p_rd = 4;  end
      endcase
      for (int c = 0; c < 150; c++) begin
        if (c % 10 == 0) iIRQ_THRESHOLD = 5'($urandom_range(0, 17));
        drive($urandom_range(0, 99) < p_rx, 8'($urandom),
              $urandom_range(0, 99) < p_rd,
              $urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < 5);
        step();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
